plot_port_arbiter: RTL
======================

Name: plot_port_arbiter

Overview:
- Shares the single VGA adapter pixel-write port (x, y, colour, plot) between several pixel producers: ship, asteroid and shot draw engines, plus the background erase engine.
- Grants the port in bursts, one producer at a time, using round-robin order.
- Registers the winning producer's pixel onto the adapter inputs.
- Sits between the draw engines and vga_adapter. It replaces direct wiring of one engine to the port.

Parameters:
NUM_REQ, 4, number of requesting draw engines (2..8)
X_W, 10, pixel x coordinate width
Y_W, 10, pixel y coordinate width
COLOR_W, 3, colour width
MAX_BURST, 64, maximum pixels accepted per grant (1..1023)

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester pixel-valid/request
last  in  NUM_REQ  per-requester "this pixel ends my burst"
req_x  in  NUM_REQ*X_W  packed x; requester i at [i*X_W +: X_W]
req_y  in  NUM_REQ*Y_W  packed y, same packing
req_color  in  NUM_REQ*COLOR_W  packed colour, same packing
gnt  out  NUM_REQ  one-hot grant, registered
x  out  X_W  pixel x to vga_adapter
y  out  Y_W  pixel y to vga_adapter
color  out  COLOR_W  pixel colour to vga_adapter
plot  out  1  pixel write strobe to vga_adapter
owner  out  clog2(NUM_REQ)  index of current grant holder (valid while busy)
busy  out  1  a grant is active

Behaviour:
- Reset (asynchronous, reset_n=0):
  - gnt=0, plot=0, x=0, y=0, color=0, owner=0, busy=0.
  - Round-robin pointer ptr=0, burst counter bcnt=0, state=IDLE.
  - Asserting reset mid-burst aborts the burst immediately. The in-flight pixel is not plotted.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - gnt=0, busy=0.
  - If any req bit is set, select the first set bit searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - Next cycle: gnt[sel]=1, owner=sel, busy=1, bcnt=0, state=GRANT.
  - Grant latency is exactly 1 cycle from the req sample.
- GRANT:
  - Accept condition: req[owner] & gnt[owner] in a cycle.
  - On accept:
    - x/y/color load the owner's slice.
    - plot=1 in the next cycle. Pixel latency is 1 cycle, up to 1 pixel/cycle sustained.
    - bcnt increments.
  - Cycles without an accept give plot=0 next cycle. x/y/color hold their last value.
  - Release happens on the first of these:
    - (a) accept with last[owner]=1;
    - (b) accept that makes bcnt equal MAX_BURST;
    - (c) req[owner]=0 while granted (no accept that cycle).
  - On release:
    - Next cycle gnt=0, busy=0, state=IDLE.
    - ptr=(owner+1) mod NUM_REQ, so the releasing requester becomes lowest priority.
  - After a release, gnt is low for exactly one cycle before any regrant.
- Requests from non-owners during GRANT are ignored; their req/x/y/color are never sampled.
- Owner keeping req high after release:
  - It waits one IDLE cycle and then competes normally.
  - It wins only if no other requester sits between ptr and it.
- The pixel accepted on the release cycle (cases a and b) is still plotted.
- Simultaneous requests in IDLE are resolved purely by ptr order, never by fixed index.
- bcnt width is clog2(MAX_BURST+1). It never wraps, because release at MAX_BURST is forced.
- No combinational path from req to gnt, plot, x, y or color. All outputs are registered.
- Requester contract:
  - Hold the pixel stable while req=1 and gnt=0.
  - Advance to the next pixel on every cycle where req=1 and gnt=1.

Test Plan:
- Reset, no requests for 20 cycles -> gnt=0, plot=0, busy=0, x=y=color=0 throughout.
- req[1] held, pixels (5,7,c=3),(6,7,3),(7,7,3), last on the third -> gnt=4'b0010 one cycle after req; plot high 3 consecutive cycles with those coordinates in order; gnt low the cycle after the third accept; ptr=2.
- req[0] and req[2] rise together from reset (ptr=0), 2-pixel bursts each, both re-request -> grant order 0, 2, 0, 2; each gnt gap exactly 1 cycle; no pixels from the loser interleaved.
- MAX_BURST=4, req[3] streams 6 pixels with last never set, req[0] also pending -> exactly 4 plots from requester 3; gnt drops; requester 0 granted next (ptr wrapped to 0); requester 3 resumes later at pixel 5.
- req[2] granted, drops req after 2 accepts without last -> exactly 2 plots; gnt low next cycle; state IDLE; ptr=3.
- reset_n pulsed low mid-burst of requester 1 -> gnt, plot, busy go 0 without waiting for clk; after release, ptr=0 and req[1],req[0] pending -> requester 0 granted first.

Source files
------------

// File: rtl/plot_port_arbiter.sv
// Round-robin burst arbiter that shares the single VGA adapter pixel-write
// port among several draw engines; the winner's pixels are registered onto the port.
module plot_port_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int COLOR_W   = 3,
    parameter int MAX_BURST = 64,
    localparam int OW       = $clog2(NUM_REQ),
    localparam int BW       = $clog2(MAX_BURST + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         last,
    input  logic [NUM_REQ*X_W-1:0]     req_x,
    input  logic [NUM_REQ*Y_W-1:0]     req_y,
    input  logic [NUM_REQ*COLOR_W-1:0] req_color,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [X_W-1:0]             x,
    output logic [Y_W-1:0]             y,
    output logic [COLOR_W-1:0]         color,
    output logic                       plot,
    output logic [OW-1:0]              owner,
    output logic                       busy
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [OW-1:0]      ptr_q, ptr_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               plot_q, plot_d;

    logic [X_W-1:0]     rx [NUM_REQ];
    logic [Y_W-1:0]     ry [NUM_REQ];
    logic [COLOR_W-1:0] rc [NUM_REQ];

    logic [OW-1:0] sel;
    logic [OW-1:0] cand;
    logic [OW-1:0] ptr_next;
    logic          found;
    logic          accept;
    logic          rel;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign rx[g] = req_x[g*X_W +: X_W];
        assign ry[g] = req_y[g*Y_W +: Y_W];
        assign rc[g] = req_color[g*COLOR_W +: COLOR_W];
    end

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = OW'((32'(ptr_q) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign ptr_next = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        bcnt_d  = bcnt_q;
        gnt_d   = gnt_q;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        plot_d  = 1'b0;
        accept  = 1'b0;
        rel     = 1'b0;
        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (found) begin
                    state_d    = S_GRANT;
                    owner_d    = sel;
                    bcnt_d     = '0;
                    gnt_d[sel] = 1'b1;
                end
            end
            default: begin
                accept = req[owner_q] & gnt_q[owner_q];
                if (accept) begin
                    plot_d  = 1'b1;
                    x_d     = rx[owner_q];
                    y_d     = ry[owner_q];
                    color_d = rc[owner_q];
                    bcnt_d  = bcnt_q + 1'b1;
                    rel     = last[owner_q] | (bcnt_q == BW'(MAX_BURST - 1));
                end else begin
                    // Owner dropped its request: give the port up.
                    rel = 1'b1;
                end
                if (rel) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            bcnt_q  <= '0;
            gnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            bcnt_q  <= bcnt_d;
            gnt_q   <= gnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            plot_q  <= plot_d;
        end
    end

    assign gnt   = gnt_q;
    assign x     = x_q;
    assign y     = y_q;
    assign color = color_q;
    assign plot  = plot_q;
    assign owner = owner_q;
    assign busy  = (state_q == S_GRANT);

endmodule
